// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants and helpers for the TMDS 8b/10b channel encoder
package tmds_pkg;

  // Width of the signed running-disparity counter; it stays within -10..+10.
  localparam int CNT_W = 5;

  // Control-period tokens, indexed by {c1,c0}.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Number of ones in an 8-bit value (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/tmds_encoder_8b10b.sv
// rtl/tmds_encoder_8b10b.sv - 3-stage pixel-rate TMDS 8b/10b encoder for one colour channel
module tmds_encoder_8b10b
  import tmds_pkg::*;
#(
  parameter logic [9:0] RST_TOKEN = 10'b1101010100
) (
  input  logic       serial_clk,
  input  logic       reset,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  input  logic [7:0] din,
  output logic [9:0] tmds_data
);

  // Stage 1 registers: sampled inputs plus the ones count of the pixel.
  logic [7:0] r_s1_din;
  logic       r_s1_de;
  logic [1:0] r_s1_c;
  logic [3:0] r_s1_n1d;

  // Stage 2 registers: transition-minimised word and its ones/zeros counts.
  logic [8:0] r_s2_qm;
  logic [3:0] r_s2_n1q;
  logic [3:0] r_s2_n0q;
  logic       r_s2_de;
  logic [1:0] r_s2_c;

  // Stage 3 state: running disparity of the transmitted stream.
  logic signed [CNT_W-1:0] r_cnt;

  logic                    w_use_xnor;
  logic [8:0]              w_qm;
  logic signed [CNT_W-1:0] w_n1q;
  logic signed [CNT_W-1:0] w_n0q;
  logic signed [CNT_W-1:0] w_q8x2;
  logic signed [CNT_W-1:0] w_nq8x2;
  logic                    w_cnt_pos;
  logic                    w_cnt_neg;
  logic                    w_case_a;
  logic                    w_case_b;
  logic [9:0]              w_video_word;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic [9:0]              w_ctrl_word;

  // Stage 1: capture inputs and count ones of the pixel.
  always_ff @(posedge serial_clk) begin
    if (reset) begin
      r_s1_din <= 8'd0;
      r_s1_de  <= 1'b0;
      r_s1_c   <= 2'b00;
      r_s1_n1d <= 4'd0;
    end else begin
      r_s1_din <= din;
      r_s1_de  <= de;
      r_s1_c   <= {c1, c0};
      r_s1_n1d <= popcount8(din);
    end
  end

  // Stage 2 combinational: pick XOR or XNOR chaining to minimise transitions.
  always_comb begin
    w_use_xnor = (r_s1_n1d > 4'd4) || ((r_s1_n1d == 4'd4) && !r_s1_din[0]);
    w_qm       = 9'd0;
    w_qm[0]    = r_s1_din[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_s1_din[i]) : (w_qm[i-1] ^ r_s1_din[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  // Stage 2: register q_m with its ones and zeros counts.
  always_ff @(posedge serial_clk) begin
    if (reset) begin
      r_s2_qm  <= 9'd0;
      r_s2_n1q <= 4'd0;
      r_s2_n0q <= 4'd0;
      r_s2_de  <= 1'b0;
      r_s2_c   <= 2'b00;
    end else begin
      r_s2_qm  <= w_qm;
      r_s2_n1q <= popcount8(w_qm[7:0]);
      r_s2_n0q <= popcount8(~w_qm[7:0]);
      r_s2_de  <= r_s1_de;
      r_s2_c   <= r_s1_c;
    end
  end

  // Stage 3 combinational: DC-balance decision and next disparity.
  always_comb begin
    w_n1q     = {1'b0, r_s2_n1q};
    w_n0q     = {1'b0, r_s2_n0q};
    w_q8x2    = {3'b000, r_s2_qm[8], 1'b0};
    w_nq8x2   = {3'b000, ~r_s2_qm[8], 1'b0};
    w_cnt_neg = r_cnt[CNT_W-1];
    w_cnt_pos = !r_cnt[CNT_W-1] && (r_cnt != '0);
    w_case_a  = (r_cnt == '0) || (w_n1q == w_n0q);
    w_case_b  = (w_cnt_pos && (w_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > w_n1q));

    if (w_case_a) begin
      w_video_word = {~r_s2_qm[8], r_s2_qm[8], r_s2_qm[8] ? r_s2_qm[7:0] : ~r_s2_qm[7:0]};
      w_cnt_next   = r_cnt + (r_s2_qm[8] ? (w_n1q - w_n0q) : (w_n0q - w_n1q));
    end else if (w_case_b) begin
      w_video_word = {1'b1, r_s2_qm[8], ~r_s2_qm[7:0]};
      w_cnt_next   = r_cnt + w_q8x2 + (w_n0q - w_n1q);
    end else begin
      w_video_word = {1'b0, r_s2_qm[8], r_s2_qm[7:0]};
      w_cnt_next   = r_cnt + (w_n1q - w_n0q) - w_nq8x2;
    end
  end

  // Stage 3 combinational: control token for the blanking period.
  always_comb begin
    w_ctrl_word = TMDS_CTRL_00;
    case (r_s2_c)
      2'b00:   w_ctrl_word = TMDS_CTRL_00;
      2'b01:   w_ctrl_word = TMDS_CTRL_01;
      2'b10:   w_ctrl_word = TMDS_CTRL_10;
      default: w_ctrl_word = TMDS_CTRL_11;
    endcase
  end

  // Stage 3: register the output word; blanking clears the disparity.
  always_ff @(posedge serial_clk) begin
    if (reset) begin
      tmds_data <= RST_TOKEN;
      r_cnt     <= '0;
    end else if (r_s2_de) begin
      tmds_data <= w_video_word;
      r_cnt     <= w_cnt_next;
    end else begin
      tmds_data <= w_ctrl_word;
      r_cnt     <= '0;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// tb/tb_tmds_encoder_8b10b.sv - scoreboard bench for the TMDS 8b/10b encoder
module tb_tmds_encoder_8b10b;

  logic       serial_clk = 1'b0;
  logic       reset;
  logic       de;
  logic       c0;
  logic       c1;
  logic [7:0] din;
  logic [9:0] tmds_data;

  always #5 serial_clk = ~serial_clk;

  tmds_encoder_8b10b #(.RST_TOKEN(10'b1101010100)) dut (
    .serial_clk(serial_clk),
    .reset     (reset),
    .de        (de),
    .c0        (c0),
    .c1        (c1),
    .din       (din),
    .tmds_data (tmds_data)
  );

  typedef struct {
    logic [9:0] word;
    int         cnt;
    bit         is_video;
    bit         has_gold;
    logic [9:0] gold;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         model_cnt = 0;
  bit         active = 0;
  bit         cur_has_gold = 0;
  logic [9:0] cur_gold = 10'd0;

  // Reference encoder written from the rules: counts, chaining choice, balance cases.
  function automatic void model_encode(input bit vid, input bit k1, input bit k0,
                                       input logic [7:0] d, inout int cnt,
                                       output logic [9:0] w);
    int   ones_d, ones_q, zeros_q, bal;
    bit   xnor_path;
    logic [7:0] q;
    bit   q8;
    if (!vid) begin
      cnt = 0;
      case ({k1, k0})
        2'b00: w = 10'b1101010100;
        2'b01: w = 10'b0010101011;
        2'b10: w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
      return;
    end
    ones_d = $countones(d);
    xnor_path = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xnor_path ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q8 = !xnor_path;
    ones_q  = $countones(q);
    zeros_q = 8 - ones_q;
    bal     = ones_q - zeros_q;
    if (cnt == 0 || bal == 0) begin
      w = {~q8, q8, q8 ? q : ~q};
      cnt = cnt + (q8 ? bal : -bal);
    end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
      w = {1'b1, q8, ~q};
      cnt = cnt + 2 * int'(q8) - bal;
    end else begin
      w = {1'b0, q8, q};
      cnt = cnt + bal - 2 * int'(!q8);
    end
  endfunction

  // Recorder: every edge, predict the word this edge's inputs will produce 3 cycles later.
  always @(posedge serial_clk) begin
    exp_t e;
    logic [9:0] w;
    if (reset) begin
      sbq.delete();
      model_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        e.word = 10'h354; e.cnt = 0; e.is_video = 0; e.has_gold = 1; e.gold = 10'h354;
        sbq.push_back(e);
      end
      active = 1;
    end else if (active) begin
      model_encode(de, c1, c0, din, model_cnt, w);
      e.word = w; e.cnt = model_cnt; e.is_video = de;
      e.has_gold = cur_has_gold; e.gold = cur_gold;
      sbq.push_back(e);
    end
  end

  // Monitor: pop one expectation per cycle and compare away from the active edge.
  int acc = 0;
  always @(negedge serial_clk) begin
    exp_t e;
    int   tr;
    if (active) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: no expected word, got %h", tmds_data);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (tmds_data !== e.word) begin
          errors++;
          $display("FAIL word: got %h expected %h", tmds_data, e.word);
        end
        checks++;
        if (int'($signed(dut.r_cnt)) != e.cnt) begin
          errors++;
          $display("FAIL cnt: got %0d expected %0d", $signed(dut.r_cnt), e.cnt);
        end
        if (e.has_gold) begin
          checks++;
          if (tmds_data !== e.gold) begin
            errors++;
            $display("FAIL directed: got %h required %h", tmds_data, e.gold);
          end
        end
        if (e.is_video) begin
          acc = acc + 2 * $countones(tmds_data) - 10;
          checks++;
          if (acc > 10 || acc < -10) begin
            errors++;
            $display("FAIL disparity: got %0d required within +-10", acc);
          end
          tr = 0;
          for (int i = 0; i < 7; i++) if (tmds_data[i] != tmds_data[i+1]) tr++;
          checks++;
          if (tr > 5) begin
            errors++;
            $display("FAIL transitions: got %0d required <=5 (word %h)", tr, tmds_data);
          end
        end else begin
          acc = 0;
        end
      end
    end
  end

  task automatic drive(input bit r, input bit v, input logic [1:0] c, input logic [7:0] x,
                       input bit gv, input logic [9:0] g);
    @(negedge serial_clk);
    reset = r; de = v; {c1, c0} = c; din = x;
    cur_has_gold = gv; cur_gold = g;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 8'($urandom), 1, 10'h354);
  endtask

  initial begin
    reset = 1'b1; de = 1'b0; c0 = 1'b0; c1 = 1'b0; din = 8'd0;
    // Two reset edges, then blanking with c=00 keeps the reset token.
    drive(1, 0, 2'b00, 8'h00, 0, 10'h0);
    blank(4);
    // Control tokens.
    drive(0, 0, 2'b01, 8'h5A, 1, 10'h0AB);
    drive(0, 0, 2'b10, 8'hA5, 1, 10'h154);
    drive(0, 0, 2'b11, 8'hFF, 1, 10'h2AB);
    blank(3);
    // All-zero pixels after blanking.
    drive(0, 1, 2'b00, 8'h00, 1, 10'h100);
    drive(0, 1, 2'b00, 8'h00, 1, 10'h3FF);
    drive(0, 1, 2'b00, 8'h00, 1, 10'h100);
    blank(3);
    // All-ones pixel, one blanking word, all-ones again.
    drive(0, 1, 2'b00, 8'hFF, 1, 10'h200);
    drive(0, 0, 2'b00, 8'hFF, 1, 10'h354);
    drive(0, 1, 2'b00, 8'hFF, 1, 10'h200);
    blank(3);
    // Random video burst interrupted by a one-cycle reset.
    for (int i = 0; i < 20; i++) drive(0, 1, 2'($urandom), 8'($urandom), 0, 10'h0);
    drive(1, 1, 2'($urandom), 8'($urandom), 0, 10'h0);
    for (int i = 0; i < 20; i++) drive(0, 1, 2'($urandom), 8'($urandom), 0, 10'h0);
    // Long random run with ~5% blanking gaps.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) < 5)
        drive(0, 0, 2'($urandom), 8'($urandom), 0, 10'h0);
      else
        drive(0, 1, 2'($urandom), 8'($urandom), 0, 10'h0);
    end
    blank(5);
    @(negedge serial_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
